// File: rtl/alt_ddrx_ddr3_odt_gen_mr_if.sv
// Command and ODT output bundle between the DDRX command arbiter and the
// multi-rank DDR3 ODT generator.
interface alt_ddrx_ddr3_odt_gen_mr_if #(
  parameter int MEM_IF_CS_WIDTH = 2
);
  logic                       do_write;
  logic                       do_read;
  logic [MEM_IF_CS_WIDTH-1:0] to_chip;
  logic [MEM_IF_CS_WIDTH-1:0] int_odt_l;
  logic [MEM_IF_CS_WIDTH-1:0] int_odt_h;
  logic                       odt_busy;
  logic                       odt_cmd_err;

  modport master (
    output do_write, do_read, to_chip,
    input  int_odt_l, int_odt_h, odt_busy, odt_cmd_err
  );

  modport slave (
    input  do_write, do_read, to_chip,
    output int_odt_l, int_odt_h, odt_busy, odt_cmd_err
  );
endinterface

// File: rtl/alt_ddrx_ddr3_odt_gen_mr.sv
// Multi-rank DDR3 ODT generator, full rate (DWIDTH_RATIO=2) or half rate (4).
// Optional ALT_DDRX_ODT_FORCE_EN adds cfg_odt_force, ORed onto the ODT outputs.
module alt_ddrx_ddr3_odt_gen_mr #(
  parameter int DWIDTH_RATIO         = 2,
  parameter int MEM_IF_CS_WIDTH      = 2,
  parameter int TCL_BUS_WIDTH        = 4,
  parameter int CAS_WR_LAT_BUS_WIDTH = 4
) (
  input  logic                                       ctl_clk,
  input  logic                                       ctl_reset_n,
  input  logic [TCL_BUS_WIDTH-1:0]                   mem_tcl,
  input  logic [CAS_WR_LAT_BUS_WIDTH-1:0]            mem_cas_wr_lat,
  input  logic                                       cfg_bl8,
  input  logic [MEM_IF_CS_WIDTH*MEM_IF_CS_WIDTH-1:0] cfg_write_odt_chip,
  input  logic [MEM_IF_CS_WIDTH*MEM_IF_CS_WIDTH-1:0] cfg_read_odt_chip,
`ifdef ALT_DDRX_ODT_FORCE_EN
  input  logic [MEM_IF_CS_WIDTH-1:0]                 cfg_odt_force,
`endif
  alt_ddrx_ddr3_odt_gen_mr_if.slave                  cmd
);
  localparam int         CS         = MEM_IF_CS_WIDTH;
  localparam bit         HALF_RATE  = (DWIDTH_RATIO == 4);
  localparam logic [3:0] PH_PER_CYC = HALF_RATE ? 4'd2 : 4'd1;

  logic [2:0]         diff_d, diff_q;
  logic [7:0]         dl_vld_d, dl_vld_q, dl_odd_d, dl_odd_q;
  logic [7:0][CS-1:0] dl_msk_d, dl_msk_q;
  logic [CS-1:0][3:0] rem_d, rem_q;
  logic [CS-1:0]      gap_d, gap_q, odt_l_d, odt_l_q, odt_h_d, odt_h_q;
  logic               busy_d, busy_q, err_d, err_q;

  logic [15:0]   lat_sub;
  logic [CS-1:0] wr_mask, rd_mask, app_mask;
  logic [7:0]    dl_ins;
  logic [2:0]    rd_dly;
  logic [3:0]    win_len, left, new_end;
  logic          wr_acc, rd_acc, rd_imm, rd_odd, multi_hot;
  logic          app_vld, app_odd, wr_hit, rd_hit;

  // Latency difference, command decode, read delay line and per-rank windows.
  always_comb begin
    lat_sub = 16'(mem_tcl) - 16'(mem_cas_wr_lat);
    if (16'(mem_tcl) <= 16'(mem_cas_wr_lat)) begin
      diff_d = 3'd0;
    end else if (lat_sub > 16'd7) begin
      diff_d = 3'd7;
    end else begin
      diff_d = lat_sub[2:0];
    end

    wr_acc    = cmd.do_write;
    rd_acc    = cmd.do_read & ~cmd.do_write;
    multi_hot = (cmd.to_chip & (cmd.to_chip - CS'(1'b1))) != {CS{1'b0}};
    err_d     = err_q | (cmd.do_write & cmd.do_read) | ((cmd.do_write | cmd.do_read) & multi_hot);

    wr_mask = {CS{1'b0}};
    rd_mask = {CS{1'b0}};
    for (int r = 0; r < CS; r++) begin
      wr_mask = wr_mask | (cmd.to_chip[r] ? cfg_write_odt_chip[r*CS +: CS] : {CS{1'b0}});
      rd_mask = rd_mask | (cmd.to_chip[r] ? cfg_read_odt_chip[r*CS +: CS] : {CS{1'b0}});
    end

    // Half rate: whole ctl cycles of delay plus an odd-phase start on h.
    rd_dly = HALF_RATE ? {1'b0, diff_q[2:1]} : diff_q;
    rd_odd = HALF_RATE ? diff_q[0] : 1'b0;
    rd_imm = rd_acc & (rd_dly == 3'd0);
    dl_ins = (rd_acc && (rd_dly != 3'd0)) ? (8'b0000_0001 << (rd_dly - 3'd1)) : 8'b0000_0000;

    dl_vld_d = {1'b0, dl_vld_q[7:1]} | dl_ins;
    dl_odd_d = {1'b0, dl_odd_q[7:1]} | (dl_ins & {8{rd_odd}});
    dl_msk_d = {{CS{1'b0}}, dl_msk_q[7:1]};
    for (int i = 0; i < 8; i++) begin
      dl_msk_d[i] = dl_msk_d[i] | (dl_ins[i] ? rd_mask : {CS{1'b0}});
    end

    app_vld  = dl_vld_q[0] | rd_imm;
    app_odd  = (dl_vld_q[0] & dl_odd_q[0]) | (rd_imm & rd_odd);
    app_mask = (dl_vld_q[0] ? dl_msk_q[0] : {CS{1'b0}}) | (rd_imm ? rd_mask : {CS{1'b0}});

    win_len = cfg_bl8 ? 4'd6 : 4'd4;
    busy_d  = |dl_vld_d;
    for (int r = 0; r < CS; r++) begin
      left    = (rem_q[r] > PH_PER_CYC) ? (rem_q[r] - PH_PER_CYC) : 4'd0;
      wr_hit  = wr_acc & wr_mask[r];
      rd_hit  = app_vld & app_mask[r];
      new_end = (rd_hit & app_odd) ? (win_len + 4'd1) : win_len;
      // A new window only extends: it starts at once if one is still running.
      if (!(wr_hit | rd_hit)) begin
        gap_d[r] = 1'b0;
        rem_d[r] = left;
      end else if (left == 4'd0) begin
        gap_d[r] = ~wr_hit & app_odd;
        rem_d[r] = new_end;
      end else begin
        gap_d[r] = 1'b0;
        rem_d[r] = (left > new_end) ? left : new_end;
      end
      odt_l_d[r] = (rem_d[r] != 4'd0) & ~gap_d[r];
      odt_h_d[r] = HALF_RATE ? (rem_d[r] > 4'd1) : (rem_d[r] != 4'd0);
      busy_d     = busy_d | (rem_d[r] != 4'd0);
    end
  end

  // State and output registers.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      diff_q   <= 3'd0;
      dl_vld_q <= 8'd0;
      dl_odd_q <= 8'd0;
      dl_msk_q <= '0;
      rem_q    <= '0;
      gap_q    <= {CS{1'b0}};
      odt_l_q  <= {CS{1'b0}};
      odt_h_q  <= {CS{1'b0}};
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      dl_vld_q <= dl_vld_d;
      dl_odd_q <= dl_odd_d;
      dl_msk_q <= dl_msk_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      odt_l_q  <= odt_l_d;
      odt_h_q  <= odt_h_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

`ifdef ALT_DDRX_ODT_FORCE_EN
  assign cmd.int_odt_l = odt_l_q | cfg_odt_force;
  assign cmd.int_odt_h = odt_h_q | cfg_odt_force;
`else
  assign cmd.int_odt_l = odt_l_q;
  assign cmd.int_odt_h = odt_h_q;
`endif
  assign cmd.odt_busy    = busy_q;
  assign cmd.odt_cmd_err = err_q;
endmodule

// File: tb/tb_alt_ddrx_ddr3_odt_gen_mr.sv
// Directed bench: a full-rate and a half-rate ODT generator side by side,
// both with two ranks, sharing clock and reset.
module tb_alt_ddrx_ddr3_odt_gen_mr;
  localparam int CS = 2;

  logic ctl_clk = 1'b0;
  logic ctl_reset_n = 1'b0;
  always #5 ctl_clk = ~ctl_clk;

  logic [3:0] fr_tcl, fr_cwl, hr_tcl, hr_cwl;
  logic       fr_bl8, hr_bl8;
  logic [3:0] fr_wr, fr_rd, hr_wr, hr_rd;
  logic [1:0] fr_force, hr_force;

  alt_ddrx_ddr3_odt_gen_mr_if #(.MEM_IF_CS_WIDTH(CS)) fr_if ();
  alt_ddrx_ddr3_odt_gen_mr_if #(.MEM_IF_CS_WIDTH(CS)) hr_if ();

  alt_ddrx_ddr3_odt_gen_mr #(.DWIDTH_RATIO(2), .MEM_IF_CS_WIDTH(CS)) u_fr (
    .ctl_clk            (ctl_clk),
    .ctl_reset_n        (ctl_reset_n),
    .mem_tcl            (fr_tcl),
    .mem_cas_wr_lat     (fr_cwl),
    .cfg_bl8            (fr_bl8),
    .cfg_write_odt_chip (fr_wr),
    .cfg_read_odt_chip  (fr_rd),
`ifdef ALT_DDRX_ODT_FORCE_EN
    .cfg_odt_force      (fr_force),
`endif
    .cmd                (fr_if.slave)
  );

  alt_ddrx_ddr3_odt_gen_mr #(.DWIDTH_RATIO(4), .MEM_IF_CS_WIDTH(CS)) u_hr (
    .ctl_clk            (ctl_clk),
    .ctl_reset_n        (ctl_reset_n),
    .mem_tcl            (hr_tcl),
    .mem_cas_wr_lat     (hr_cwl),
    .cfg_bl8            (hr_bl8),
    .cfg_write_odt_chip (hr_wr),
    .cfg_read_odt_chip  (hr_rd),
`ifdef ALT_DDRX_ODT_FORCE_EN
    .cfg_odt_force      (hr_force),
`endif
    .cmd                (hr_if.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ctl_clk);
    #1;
  endtask

  logic e0, e1;

  initial begin
    fr_tcl = 4'd8; fr_cwl = 4'd5; fr_bl8 = 1'b1;
    fr_wr  = 4'b1011;   // rank0 write -> ranks 1,0 ; rank1 write -> rank1
    fr_rd  = 4'b1001;   // rank0 read  -> rank0     ; rank1 read  -> rank1
    hr_tcl = 4'd6; hr_cwl = 4'd5; hr_bl8 = 1'b0;
    hr_wr  = 4'b1001;
    hr_rd  = 4'b0100;   // rank1 read -> rank0
    fr_force = 2'b00; hr_force = 2'b00;
    fr_if.do_write = 1'b0; fr_if.do_read = 1'b0; fr_if.to_chip = 2'b00;
    hr_if.do_write = 1'b0; hr_if.do_read = 1'b0; hr_if.to_chip = 2'b00;

    tick(); tick();
    chk("rst_fr_l", fr_if.int_odt_l, 2'b00);
    chk("rst_fr_busy", fr_if.odt_busy, 1'b0);
    chk("rst_fr_err", fr_if.odt_cmd_err, 1'b0);
    chk("rst_hr_h", hr_if.int_odt_h, 2'b00);
    ctl_reset_n = 1'b1;
    tick(); tick(); tick();

    // Full-rate BL8 write to rank0: both ranks high for cycles 1..6.
    for (int c = 0; c <= 8; c++) begin
      fr_if.do_write = (c == 0);
      fr_if.to_chip  = 2'b01;
      e0 = (c >= 1) && (c <= 6);
      chk("fr_wr_l", fr_if.int_odt_l, {e0, e0});
      chk("fr_wr_h", fr_if.int_odt_h, {e0, e0});
      chk("fr_wr_busy", fr_if.odt_busy, e0);
      tick();
    end

    // Half-rate BC4 read, diff=1: starts on h of cycle 1, ends on l of cycle 3.
    for (int c = 0; c <= 4; c++) begin
      hr_if.do_read = (c == 0);
      hr_if.to_chip = 2'b10;
      chk("hr_rd_l", hr_if.int_odt_l, {1'b0, (c == 2) || (c == 3)});
      chk("hr_rd_h", hr_if.int_odt_h, {1'b0, (c == 1) || (c == 2)});
      chk("hr_rd_busy", hr_if.odt_busy, (c >= 1) && (c <= 3));
      tick();
    end

    // Half-rate write with a two-hot target: OR mask, flagged as error.
    for (int c = 0; c <= 3; c++) begin
      hr_if.do_write = (c == 0);
      hr_if.to_chip  = 2'b11;
      e0 = (c == 1) || (c == 2);
      chk("hr_multi_l", hr_if.int_odt_l, {e0, e0});
      chk("hr_multi_h", hr_if.int_odt_h, {e0, e0});
      chk("hr_multi_err", hr_if.odt_cmd_err, c >= 1);
      tick();
    end

    // Full-rate diff=3 read then write on rank0: windows 4..9 and 5..10 merge.
    for (int c = 0; c <= 11; c++) begin
      fr_if.do_read  = (c == 0);
      fr_if.do_write = (c == 4);
      fr_if.to_chip  = 2'b01;
      e0 = (c >= 4) && (c <= 10);
      e1 = (c >= 5) && (c <= 10);
      chk("fr_merge_l", fr_if.int_odt_l, {e1, e0});
      chk("fr_merge_h", fr_if.int_odt_h, {e1, e0});
      chk("fr_merge_busy", fr_if.odt_busy, (c >= 1) && (c <= 10));
      tick();
    end
    chk("fr_err_clean", fr_if.odt_cmd_err, 1'b0);

    // Write and read together: write only, read dropped, sticky error.
    for (int c = 0; c <= 10; c++) begin
      fr_if.do_write = (c == 0);
      fr_if.do_read  = (c == 0);
      fr_if.to_chip  = 2'b01;
      e0 = (c >= 1) && (c <= 6);
      chk("fr_both_l", fr_if.int_odt_l, {e0, e0});
      chk("fr_both_busy", fr_if.odt_busy, e0);
      chk("fr_both_err", fr_if.odt_cmd_err, c >= 1);
      tick();
    end
    fr_if.do_write = 1'b0; fr_if.do_read = 1'b0;

    // Reset in the middle of a BL8 window with a read still in the delay line.
    for (int c = 0; c <= 3; c++) begin
      fr_if.do_write = (c == 0);
      fr_if.do_read  = (c == 1);
      fr_if.to_chip  = (c == 1) ? 2'b10 : 2'b01;
      chk("fr_pre_rst_l", fr_if.int_odt_l, (c >= 1) ? 2'b11 : 2'b00);
      chk("fr_err_sticky", fr_if.odt_cmd_err, 1'b1);
      if (c < 3) tick();
    end
    fr_if.do_write = 1'b0; fr_if.do_read = 1'b0;
    ctl_reset_n = 1'b0;
    #1;
    chk("fr_async_rst_l", fr_if.int_odt_l, 2'b00);
    chk("fr_async_rst_h", fr_if.int_odt_h, 2'b00);
    chk("fr_async_rst_err", fr_if.odt_cmd_err, 1'b0);
    tick();
    chk("fr_in_rst_l", fr_if.int_odt_l, 2'b00);
    tick();
    ctl_reset_n = 1'b1;
    for (int c = 5; c <= 12; c++) begin
      chk("fr_post_rst_l", fr_if.int_odt_l, 2'b00);
      chk("fr_post_rst_h", fr_if.int_odt_h, 2'b00);
      chk("fr_post_rst_busy", fr_if.odt_busy, 1'b0);
      tick();
    end

`ifdef ALT_DDRX_ODT_FORCE_EN
    fr_force = 2'b10;
    #1;
    chk("fr_force_l", fr_if.int_odt_l, 2'b10);
    chk("fr_force_h", fr_if.int_odt_h, 2'b10);
    tick();
    chk("fr_force_busy", fr_if.odt_busy, 1'b0);
    fr_force = 2'b00;
    #1;
    chk("fr_force_off", fr_if.int_odt_l, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
